spi_register_writer: RTL and testbench

//   SPI master that drives register-write frames into the on-chip SPI register receiver
//   (colour, sprite position and misc registers). Each accepted request becomes one

---
 rtl/spi_register_writer.sv | 114 +++++++++++
 tb/tb_spi_register_writer.sv | 242 ++++++++++++++++++++++++
 2 files changed

// File: rtl/spi_register_writer.sv
// SPI master that serialises one {cmd, data} register-write frame per accepted request,
// MSB first, with CLK_DIV system cycles per sclk half-period.
module spi_register_writer #(
   parameter int CMD_WIDTH  = 8,
   parameter int DATA_WIDTH = 8,
   parameter int CLK_DIV    = 2
) (
   input  logic                  clk_i,
   input  logic                  rst_i,
   input  logic                  enable,
   input  logic                  req_valid,
   output logic                  req_ready,
   input  logic [CMD_WIDTH-1:0]  req_cmd,
   input  logic [DATA_WIDTH-1:0] req_data,
   output logic                  busy,
   output logic                  done,
   output logic                  spi_cs_n,
   output logic                  spi_sclk,
   output logic                  spi_mosi,
   input  logic                  spi_miso
);

   localparam int N     = CMD_WIDTH + DATA_WIDTH;
   localparam int CNT_W = $clog2(N + 1);
   localparam logic [7:0]       DIV_LAST = 8'(CLK_DIV - 1);
   localparam logic [CNT_W-1:0] BIT_LAST = CNT_W'(N - 1);

   typedef enum logic [1:0] {IDLE, LEAD, SHIFT, GAP} state_t;

   state_t           state;
   logic [N-1:0]     shreg;
   logic [CNT_W-1:0] bit_cnt;
   logic [7:0]       div_cnt;
   logic             div_end;
   logic [N-1:0]     req_word;
   logic             unused_miso;

   assign unused_miso = spi_miso;
   assign req_word    = {req_cmd, req_data};
   assign div_end     = (div_cnt == DIV_LAST);
   assign req_ready   = (state == IDLE) && enable;

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         state    <= IDLE;
         shreg    <= '0;
         bit_cnt  <= '0;
         div_cnt  <= '0;
         busy     <= 1'b0;
         done     <= 1'b0;
         spi_cs_n <= 1'b1;
         spi_sclk <= 1'b0;
         spi_mosi <= 1'b0;
      end else begin
         done <= 1'b0;
         case (state)
            IDLE: begin
               if (req_valid && req_ready) begin
                  state    <= LEAD;
                  shreg    <= req_word;
                  bit_cnt  <= '0;
                  div_cnt  <= '0;
                  busy     <= 1'b1;
                  spi_cs_n <= 1'b0;
                  spi_mosi <= req_word[N-1];
               end
            end
            LEAD: begin
               if (div_end) begin
                  div_cnt  <= '0;
                  spi_sclk <= 1'b1;
                  state    <= SHIFT;
               end else begin
                  div_cnt <= div_cnt + 8'd1;
               end
            end
            SHIFT: begin
               if (!div_end) begin
                  div_cnt <= div_cnt + 8'd1;
               end else begin
                  div_cnt <= '0;
                  if (spi_sclk) begin
                     spi_sclk <= 1'b0;
                  end else begin
                     // end of low phase: advance to the next bit, presented on the rising edge
                     shreg   <= shreg << 1;
                     bit_cnt <= bit_cnt + CNT_W'(1);
                     if (bit_cnt == BIT_LAST) begin
                        state    <= GAP;
                        spi_cs_n <= 1'b1;
                        spi_mosi <= 1'b0;
                     end else begin
                        spi_sclk <= 1'b1;
                        spi_mosi <= shreg[N-2];
                     end
                  end
               end
            end
            GAP: begin
               if (div_end) begin
                  div_cnt <= '0;
                  state   <= IDLE;
                  busy    <= 1'b0;
                  done    <= 1'b1;
               end else begin
                  div_cnt <= div_cnt + 8'd1;
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_spi_register_writer.sv
// Scoreboard bench: three writers (CLK_DIV 2, 1, 5); expected frames are queued at
// issue time and a negedge monitor decodes the SPI lines and checks timing.
module tb_spi_register_writer;

   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic       enable = 1'b1;
   logic [2:0] req_valid = '0;
   logic [2:0] req_ready, busy, done, cs_n, sclk, mosi;
   logic [7:0] req_cmd  [3] = '{8'h00, 8'h00, 8'h00};
   logic [7:0] req_data [3] = '{8'h00, 8'h00, 8'h00};

   int n_cmp = 0;
   int n_bad = 0;
   longint cyc = 0;

   logic [15:0] exp_q [3][$];
   logic [7:0]  rx_regs [16];

   always #5 clk = ~clk;
   always @(posedge clk) cyc++;

   function automatic int div_of(input int g);
      return (g == 0) ? 2 : ((g == 1) ? 1 : 5);
   endfunction

   for (genvar g = 0; g < 3; g++) begin : g_dut
      spi_register_writer #(
         .CMD_WIDTH(8), .DATA_WIDTH(8), .CLK_DIV((g == 0) ? 2 : ((g == 1) ? 1 : 5))
      ) u_dut (
         .clk_i(clk), .rst_i(rst), .enable(enable),
         .req_valid(req_valid[g]), .req_ready(req_ready[g]),
         .req_cmd(req_cmd[g]), .req_data(req_data[g]),
         .busy(busy[g]), .done(done[g]),
         .spi_cs_n(cs_n[g]), .spi_sclk(sclk[g]), .spi_mosi(mosi[g]),
         .spi_miso(1'b0)
      );
   end

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", nm, act, exp, $time);
      end
   endtask

   // ---------------- monitor / scoreboard ----------------
   int          falls [3] = '{0, 0, 0};
   int          rises [3] = '{0, 0, 0};
   int          cs_lo [3] = '{0, 0, 0};
   int          cs_hi [3] = '{0, 0, 0};
   int          age   [3] = '{0, 0, 0};
   longint      acc_cyc [3], fall_cyc [3], rise_cyc [3];
   logic [15:0] frame [3] = '{16'h0, 16'h0, 16'h0};
   logic        sclk_p [3] = '{1'b0, 1'b0, 1'b0};
   logic        cs_p   [3] = '{1'b1, 1'b1, 1'b1};
   logic        mosi_p [3] = '{1'b0, 1'b0, 1'b0};
   logic        fmosi  [3] = '{1'b0, 1'b0, 1'b0};
   logic        rst_d = 1'b1;

   initial for (int i = 0; i < 16; i++) rx_regs[i] = 8'h00;

   always @(negedge clk) begin
      for (int g = 0; g < 3; g++) begin
         int d;
         logic just_done;
         logic [15:0] e;
         d = div_of(g);
         just_done = 1'b0;
         if (rst || rst_d) begin
            falls[g] = 0; rises[g] = 0; cs_lo[g] = 0; frame[g] = '0;
         end else begin
            if (done[g]) begin
               just_done = 1'b1;
               if (exp_q[g].size() == 0) begin
                  chk($sformatf("unexpected_done[%0d]", g), 1, 0);
               end else begin
                  e = exp_q[g].pop_front();
                  chk($sformatf("frame_bits[%0d]", g), frame[g], e);
                  chk($sformatf("fall_count[%0d]", g), falls[g], 16);
                  chk($sformatf("rise_count[%0d]", g), rises[g], 16);
                  chk($sformatf("latency[%0d]", g), 32'(cyc - acc_cyc[g]), 34 * d + 1);
                  chk($sformatf("cs_low_cycles[%0d]", g), cs_lo[g], 33 * d);
               end
            end
            if (req_valid[g] && req_ready[g]) begin
               if (just_done) chk($sformatf("cs_hi_gap[%0d]", g), cs_hi[g] + 1, d + 1);
               acc_cyc[g] = cyc;
               falls[g] = 0; rises[g] = 0; cs_lo[g] = 0; frame[g] = '0;
            end
            if (!cs_n[g]) cs_lo[g]++;
            if (cs_n[g]) chk($sformatf("sclk_idle[%0d]", g), sclk[g], 0);
            if (sclk_p[g] && !sclk[g]) begin
               chk($sformatf("cs_at_fall[%0d]", g), cs_n[g], 0);
               chk($sformatf("setup[%0d]", g), (mosi[g] == mosi_p[g]) && (age[g] >= d), 1);
               frame[g] = {frame[g][14:0], mosi[g]};
               falls[g]++;
               fmosi[g] = mosi[g];
               fall_cyc[g] = cyc;
            end
            if (!sclk_p[g] && sclk[g]) begin
               if (rises[g] > 0) begin
                  chk($sformatf("hold[%0d]", g), mosi_p[g], fmosi[g]);
                  chk($sformatf("low_phase[%0d]", g), 32'(cyc - fall_cyc[g]), d);
                  chk($sformatf("sclk_period[%0d]", g), 32'(cyc - rise_cyc[g]), 2 * d);
               end
               rise_cyc[g] = cyc;
               rises[g]++;
            end
            if (g == 0 && !cs_p[g] && cs_n[g] && falls[g] == 16)
               rx_regs[frame[g][11:8]] = frame[g][7:0];
         end
         if (mosi[g] !== mosi_p[g]) age[g] = 1; else age[g]++;
         if (cs_n[g]) cs_hi[g]++; else cs_hi[g] = 0;
         sclk_p[g] = sclk[g];
         cs_p[g]   = cs_n[g];
         mosi_p[g] = mosi[g];
      end
      rst_d = rst;
   end

   // ---------------- stimulus ----------------
   task automatic tick(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   task automatic wait_idle();
      int t;
      t = 0;
      while ((exp_q[0].size() + exp_q[1].size() + exp_q[2].size()) != 0 && t < 3000) begin
         tick(1);
         t++;
      end
      if (t >= 3000) chk("drain_timeout", 1, 0);
      tick(2);
   endtask

   task automatic send0(input logic [7:0] c, input logic [7:0] dt);
      req_cmd[0] = c; req_data[0] = dt; req_valid[0] = 1'b1;
      tick(1);
      req_valid[0] = 1'b0;
   endtask

   initial begin
      tick(3);
      chk("rst_cs_n", cs_n[0], 1);
      chk("rst_sclk", sclk[0], 0);
      chk("rst_mosi", mosi[0], 0);
      chk("rst_busy", busy[0], 0);
      chk("rst_done", done[0], 0);
      rst = 1'b0;
      tick(1);
      chk("ready_after_rst", req_ready, 3'b111);

      // Concurrent single frames at CLK_DIV 2, 1 and 5
      req_cmd  = '{8'h04, 8'h12, 8'h81};
      req_data = '{8'hA5, 8'h3C, 8'h7E};
      exp_q[0].push_back(16'h04A5);
      exp_q[1].push_back(16'h123C);
      exp_q[2].push_back(16'h817E);
      req_valid = 3'b111;
      tick(1);
      req_valid = 3'b000;
      chk("busy_in_frame", busy, 3'b111);
      wait_idle();
      chk("rx_sprite_x", rx_regs[4], 8'hA5);

      // Three back-to-back requests with req_valid held high
      for (int k = 0; k < 3; k++) exp_q[0].push_back({8'(k), 8'(8'h11 * (k + 1))});
      req_valid[0] = 1'b1;
      for (int k = 0; k < 3; k++) begin
         int t;
         req_cmd[0] = 8'(k);
         req_data[0] = 8'(8'h11 * (k + 1));
         t = 0;
         while (!req_ready[0] && t < 200) begin tick(1); t++; end
         if (t >= 200) chk("b2b_accept_timeout", 1, 0);
         tick(1);
      end
      req_valid[0] = 1'b0;
      wait_idle();
      chk("rx_reg2", rx_regs[2], 8'h33);

      // enable low blocks new requests
      enable = 1'b0;
      req_cmd[0] = 8'h07; req_data[0] = 8'h55; req_valid[0] = 1'b1;
      for (int k = 0; k < 4; k++) begin
         tick(2);
         chk("ready_when_disabled", req_ready[0], 0);
         chk("cs_when_disabled", cs_n[0], 1);
      end
      req_valid[0] = 1'b0;
      enable = 1'b1;

      // enable dropped at bit 5: frame still completes
      exp_q[0].push_back(16'h03C3);
      send0(8'h03, 8'hC3);
      tick(22);
      enable = 1'b0;
      chk("busy_at_bit5", busy[0], 1);
      wait_idle();
      enable = 1'b1;
      chk("rx_reg3", rx_regs[3], 8'hC3);

      // reset at bit 9: frame dropped, no done
      send0(8'h05, 8'h3C);
      tick(38);
      chk("busy_at_bit9", busy[0], 1);
      rst = 1'b1;
      tick(1);
      chk("abort_cs_n", cs_n[0], 1);
      chk("abort_sclk", sclk[0], 0);
      chk("abort_mosi", mosi[0], 0);
      chk("abort_busy", busy[0], 0);
      chk("abort_done", done[0], 0);
      rst = 1'b0;
      chk("ready_after_abort", req_ready[0], 1);
      tick(80);
      chk("abort_no_write", rx_regs[5], 8'h00);

      // reset coincident with a handshake: nothing starts
      rst = 1'b1;
      req_cmd[0] = 8'h06; req_data[0] = 8'h99; req_valid[0] = 1'b1;
      tick(1);
      rst = 1'b0;
      req_valid[0] = 1'b0;
      for (int k = 0; k < 5; k++) begin
         tick(1);
         chk("rst_hs_cs_n", cs_n[0], 1);
      end
      chk("rst_hs_busy", busy[0], 0);
      tick(80);
      chk("rst_hs_no_write", rx_regs[6], 8'h00);

      wait_idle();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
